// File: rtl/xu0_bprm_seq.sv
// bpermd sequencer for the XU0 pipe: feeds LANES single-bit permute selectors per cycle,
// gathers their outputs into the 8-bit result and returns it over a valid/ready handshake.

module xu0_bprm (
  input  logic [0:7]  sel,
  input  logic [0:63] rb,
  output logic        res
);
  // Selectors of 64 or more pick nothing.
  assign res = (sel[0:1] == 2'b00) ? rb[sel[2:7]] : 1'b0;
endmodule

module xu0_bprm_seq #(
  parameter int unsigned LANES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [0:63] in_rs,
  input  logic [0:63] in_rb,
  input  logic [0:6]  in_itag,
  output logic        out_val,
  input  logic        out_rdy,
  output logic [0:63] out_rt,
  output logic [0:6]  out_itag
);
  localparam int unsigned Steps = 8 / LANES;
  localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Steps - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [0:63]     rs_q;
  logic [0:63]     rb_q;
  logic [0:6]      itag_q;
  logic [0:7]      acc_q;
  logic            out_val_q;

  logic [LANES-1:0] lane_res;
  logic [2:0]       lane_idx [LANES];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_idx[k] = 3'(int'(cnt_q) * LANES + k);
    xu0_bprm u_bprm (
      .sel (rs_q[{lane_idx[k], 3'b000} +: 8]),
      .rb  (rb_q),
      .res (lane_res[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rs_q      <= '0;
      rb_q      <= '0;
      itag_q    <= '0;
      acc_q     <= '0;
      out_val_q <= 1'b0;
    end else if (flush) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      out_val_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_val) begin
            rs_q    <= in_rs;
            rb_q    <= in_rb;
            itag_q  <= in_itag;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          for (int k = 0; k < LANES; k++) begin
            acc_q[lane_idx[k]] <= lane_res[k];
          end
          // Hold cnt on the last group so it never wraps.
          if (cnt_q == CntLast) begin
            state_q   <= StDone;
            out_val_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (out_rdy) begin
            state_q   <= StIdle;
            out_val_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_rdy   = (state_q == StIdle);
  assign out_val  = out_val_q;
  assign out_rt   = {56'b0, acc_q};
  assign out_itag = itag_q;

endmodule

// File: tb/tb_xu0_bprm_seq.sv
// Bench for xu0_bprm_seq: LANES=1, 2 and 8 instances run the same sequence in parallel,
// with results checked against a scoreboard of expected doublewords and tags.

module tb_xu0_bprm_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [0:63] bperm(input logic [0:63] rs, input logic [0:63] rb);
    logic [0:63] r;
    logic [7:0]  s;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      s = rs[8*i +: 8];
      r[56+i] = (s < 8'd64) ? rb[s[5:0]] : 1'b0;
    end
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned Ln    = (g == 0) ? 1 : (g == 1) ? 2 : 8;
    localparam int unsigned Steps = 8 / Ln;

    logic        rst_n, flush, in_val, in_rdy, out_val, out_rdy;
    logic [0:63] in_rs, in_rb, out_rt;
    logic [0:6]  in_itag, out_itag;
    logic        done = 1'b0;
    logic [0:63] exp_rt_q[$];
    logic [0:6]  exp_tag_q[$];

    xu0_bprm_seq #(.LANES(Ln)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_val   (in_val),
      .in_rdy   (in_rdy),
      .in_rs    (in_rs),
      .in_rb    (in_rb),
      .in_itag  (in_itag),
      .out_val  (out_val),
      .out_rdy  (out_rdy),
      .out_rt   (out_rt),
      .out_itag (out_itag)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      check($sformatf("L%0d %s", Ln, nm), got, exp);
    endtask

    // Drives one request; returns one time unit after the accepting edge.
    task automatic send(input logic [0:63] rs, input logic [0:63] rb, input logic [0:6] tag);
      @(negedge clk);
      chk("in_rdy before accept", in_rdy, 1);
      in_val  = 1'b1;
      in_rs   = rs;
      in_rb   = rb;
      in_itag = tag;
      @(posedge clk);
      #1 in_val = 1'b0;
    endtask

    // Counts negedges after accept until out_val is seen; bounded.
    task automatic wait_out(output int cyc);
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        chk("in_rdy low while in flight", in_rdy, 0);
      end while (!out_val && cyc < 20);
      chk("out_val seen", out_val, 1);
    endtask

    task automatic collect(input string nm);
      logic [0:63] e;
      logic [0:6]  t;
      if (exp_rt_q.size() == 0) begin
        chk({nm, " scoreboard empty"}, 0, 1);
      end else begin
        e = exp_rt_q.pop_front();
        t = exp_tag_q.pop_front();
        chk({nm, " rt"}, out_rt, e);
        chk({nm, " itag"}, out_itag, 64'(t));
      end
    endtask

    task automatic run_op(input string nm, input logic [0:63] rs, input logic [0:63] rb,
                          input logic [0:6] tag, input logic [0:63] exp);
      int cyc;
      out_rdy = 1'b1;
      send(rs, rb, tag);
      exp_rt_q.push_back(exp);
      exp_tag_q.push_back(tag);
      wait_out(cyc);
      chk({nm, " latency"}, 64'(cyc), 64'(Steps + 1));
      collect(nm);
      @(negedge clk);
      chk({nm, " in_rdy after handshake"}, in_rdy, 1);
      chk({nm, " out_val after handshake"}, out_val, 0);
    endtask

    initial begin
      int          cyc;
      logic [0:63] hold_rt, rs, rb;
      logic [0:6]  hold_tag;
      rst_n = 1'b0; flush = 1'b0; in_val = 1'b0; out_rdy = 1'b1;
      in_rs = '0; in_rb = '0; in_itag = '0;
      #12;
      chk("reset out_val", out_val, 0);
      chk("reset out_rt", out_rt, 0);
      chk("reset out_itag", out_itag, 0);
      chk("reset in_rdy", in_rdy, 1);
      @(negedge clk) rst_n = 1'b1;

      run_op("basic", 64'h003F_40FF_013E_003F, 64'h8000_0000_0000_0001, 7'h55,
             64'h0000_0000_0000_00C3);

      // Back-pressure: result must hold while out_rdy is low.
      out_rdy = 1'b0;
      rs = 64'h0102_0304_0506_0708;
      rb = 64'h5A5A_A5A5_0F0F_F0F0;
      send(rs, rb, 7'h2A);
      exp_rt_q.push_back(bperm(rs, rb));
      exp_tag_q.push_back(7'h2A);
      wait_out(cyc);
      hold_rt  = out_rt;
      hold_tag = out_itag;
      repeat (6) begin
        @(negedge clk);
        chk("stall out_val", out_val, 1);
        chk("stall out_rt", out_rt, hold_rt);
        chk("stall out_itag", out_itag, 64'(hold_tag));
        chk("stall in_rdy", in_rdy, 0);
      end
      out_rdy = 1'b1;
      collect("stall");
      @(negedge clk);
      chk("stall release in_rdy", in_rdy, 1);
      chk("stall release out_val", out_val, 0);

      // Flush mid-BUSY (third BUSY cycle, or the only one for LANES=8).
      send(64'h3F3F_3F3F_3F3F_3F3F, 64'h0000_0000_0000_0001, 7'h11);
      repeat ((Steps < 3) ? Steps : 3) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      repeat (Steps + 3) begin
        @(negedge clk);
        chk("flushed out_val", out_val, 0);
        chk("flushed in_rdy", in_rdy, 1);
      end
      run_op("after flush", 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 7'h33, 64'h0000_0000_0000_00FF);

      // Flush together with in_val in IDLE: request is dropped.
      @(negedge clk);
      in_val = 1'b1; flush = 1'b1;
      in_rs = 64'h0; in_rb = 64'hFFFF_FFFF_FFFF_FFFF; in_itag = 7'h44;
      @(posedge clk);
      #1 in_val = 1'b0; flush = 1'b0;
      repeat (Steps + 3) begin
        @(negedge clk);
        chk("idle flush out_val", out_val, 0);
        chk("idle flush in_rdy", in_rdy, 1);
      end

      // Flush together with the output handshake: transfer still counts.
      out_rdy = 1'b0;
      rs = 64'hFF40_3F00_2010_0807;
      rb = 64'hDEAD_BEEF_CAFE_F00D;
      send(rs, rb, 7'h66);
      exp_rt_q.push_back(bperm(rs, rb));
      exp_tag_q.push_back(7'h66);
      wait_out(cyc);
      out_rdy = 1'b1;
      flush   = 1'b1;
      collect("flush+handshake");
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush+handshake in_rdy", in_rdy, 1);
      chk("flush+handshake out_val", out_val, 0);

      // Asynchronous reset mid-BUSY, off the clock edge.
      send(64'h003F_40FF_013E_003F, 64'h8000_0000_0000_0001, 7'h77);
      repeat ((Steps > 1) ? Steps - 1 : 1) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset out_val", out_val, 0);
      chk("async reset out_rt", out_rt, 0);
      chk("async reset out_itag", out_itag, 0);
      chk("async reset in_rdy", in_rdy, 1);
      @(negedge clk);
      #3 rst_n = 1'b1;
      run_op("after reset", 64'h003F_40FF_013E_003F, 64'h8000_0000_0000_0001, 7'h0F,
             64'h0000_0000_0000_00C3);

      for (int n = 0; n < 4; n++) begin
        for (int i = 0; i < 8; i++) rs[8*i +: 8] = 8'($urandom_range(0, 95));
        rb = {$urandom, $urandom};
        run_op($sformatf("rand%0d", n), rs, rb, 7'($urandom), bperm(rs, rb));
      end
      done = 1'b1;
    end
  end

  initial begin
    fork
      wait (g_inst[0].done && g_inst[1].done && g_inst[2].done);
      #50000;
    join_any
    check("sequences complete", 64'(g_inst[0].done && g_inst[1].done && g_inst[2].done), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xu0_bprm_seq.md
# xu0_bprm_seq

Multi-cycle sequencer for the bpermd (bit permute doubleword) operation in the XU0 execution pipe. It sits directly upstream of the single-bit permute selector stage (`xu0_bprm`) and instantiates `LANES` copies of it. Each cycle it feeds those copies one group of selector bytes from RS plus the full RB source, then collects their single-bit outputs into the 8-bit bpermd result. It presents the finished doubleword to the XU0 result mux through a valid/ready handshake.

## Interface
Parameters:
- `LANES`, default 2: number of `xu0_bprm` instances, i.e. selector bytes processed per cycle. Legal values are 1, 2, 4 and 8.

Ports:
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `flush`  in  1: kills the in-flight operation.
- `in_val`  in  1: operation request valid.
- `in_rdy`  out  1: sequencer can accept a request.
- `in_rs`  in  [0:63]: selector doubleword; byte i is `in_rs[8i:8i+7]`.
- `in_rb`  in  [0:63]: source doubleword whose bits are selected.
- `in_itag`  in  [0:6]: instruction tag, returned with the result.
- `out_val`  out  1: result valid.
- `out_rdy`  in  1: consumer accepts the result.
- `out_rt`  out  [0:63]: result; bits 0:55 are always zero and bits 56:63 hold the permuted bits.
- `out_itag`  out  [0:6]: tag of the result.

## Operation
- Bit numbering is big-endian: bit 0 is the MSB.
- Result bit `out_rt[56+i]` equals `rb[sel_i]` when `sel_i` < 64, else 0, where `sel_i` = RS byte i.
- The out-of-range case (`sel_i[0:1]` ≠ 00) resolves to 0 inside `xu0_bprm`; the sequencer adds no extra masking.
- Lane k in step j is driven with selector byte `j*LANES+k` and the captured RB. Its output is written into accumulator bit `j*LANES+k`.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: `in_rdy`=1. On `in_val` & !`flush`, the sequencer captures RS, RB and itag, clears the accumulator, sets step counter `cnt`=0, and moves to BUSY.
  - BUSY: `in_rdy`=0. Each cycle it processes one group and increments `cnt`. On the group where `cnt` = 8/LANES−1 it writes the final bits and moves to DONE.
  - DONE: `out_val`=1. `out_rt` and `out_itag` are held stable. On `out_rdy` it moves to IDLE.
- `cnt` is log2(8/LANES) bits wide, with a minimum of 1 bit, and never wraps during an operation.
- `in_rdy` is decoded combinationally from state only; it does not depend on `out_rdy`. There is no overlap: a new request is accepted no earlier than the cycle after the output handshake.
- Flush takes priority over all other transitions: from any state, the next state is IDLE and the accumulator contents are discarded.
  - Flush in the same cycle as `in_val` in IDLE: the request is not accepted.
  - Flush in the same cycle as `out_val` & `out_rdy`: the transfer still counts, because `out_val` is high that cycle. The next state is IDLE.
- Reset, including reset asserted mid-operation: the state goes to IDLE immediately and asynchronously. `out_val`=0, `out_rt`=0, `out_itag`=0, `cnt`=0, accumulator=0, and `in_rdy`=1.

## Timing
- A request is accepted at rising edge N, when `in_val` & `in_rdy` are both high.
- The BUSY cycles are N+1 through N+8/LANES.
- `out_val` rises at N+8/LANES+1: 2 cycles for LANES=8, 3 for LANES=4, 5 for LANES=2, and 9 for LANES=1.
- Back-to-back throughput is one operation per 8/LANES+2 cycles when `out_rdy` is held high.
- The `xu0_bprm` path is combinational from the captured registers into the accumulator. No output is driven combinationally from any input except `in_rdy`, which is decoded from state.

## Test plan
- LANES=2, RB=0x8000_0000_0000_0001, RS=0x003F_40FF_013E_003F, `out_rdy`=1 -> `out_val` 5 cycles after accept, `out_rt`=0x0000_0000_0000_00C3, `out_itag` equal to the input tag.
- LANES=1 and LANES=8 with the same stimulus -> identical result; `out_val` at +9 and +2 respectively; `in_rdy` low from accept until the cycle after the output handshake.
- `out_rdy` held low for 6 cycles in DONE -> `out_val`, `out_rt` and `out_itag` stable throughout, `in_rdy`=0; `out_rdy`=1 -> IDLE next cycle, `in_rdy`=1.
- LANES=1, `flush` in the 3rd BUSY cycle -> no `out_val`, `in_rdy`=1 the next cycle. A following op with RS=0x0000_0000_0000_0000 and RB=0xFFFF_FFFF_FFFF_FFFF returns 0x0000_0000_0000_00FF, with no stale bits from the flushed op.
- Flush coincident with `in_val` in IDLE -> not accepted; flush coincident with the output handshake -> transfer completes and the next state is IDLE.
- `rst_n` pulsed low mid-BUSY, not aligned to `clk` -> `out_val`=0 and `out_rt`=0 immediately, `in_rdy`=1; a normal op after release completes correctly.
